// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    localparam int CNT_W        = 6;
    localparam int MULT_LAT_DEF = 34;
    localparam int DIV_LAT_DEF  = 34;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for an external multiplier/divider; owns HI/LO.
// Define MULDIV_DIV_EN to enable division; otherwise DIV reports err.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        mult_ctrl,
    output logic        div_ctrl,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        err
);

    if (MULT_LAT < 2 || MULT_LAT > 63) begin : g_bad_mult
        $error("MULT_LAT out of range 2..63");
    end
    if (DIV_LAT < 2 || DIV_LAT > 63) begin : g_bad_div
        $error("DIV_LAT out of range 2..63");
    end

    localparam logic [CNT_W-1:0] MULT_END = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_END  = CNT_W'(DIV_LAT - 1);

    state_t           state;
    op_t              op_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_end;
    op_t              op_in;
    logic             reject;

    assign op_in   = op_t'(op);
    assign cnt_end = (op_q == OP_DIV) ? DIV_END : MULT_END;
    assign busy    = (state != IDLE);

`ifdef MULDIV_DIV_EN
    assign reject = (op_in == OP_DIV) && (rt_val == 32'd0);
`else
    // No divider present: every DIV request is refused.
    logic unused_div;
    assign unused_div = ^{div_q, div_r};
    assign reject     = (op_in == OP_DIV);
    assign div_ctrl   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= OP_MULT;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            mult_ctrl <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_ctrl  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op_in;
                        op_a <= rs_val;
                        op_b <= rt_val;
                        cnt  <= '0;
                        err  <= 1'b0;
                        if (reject) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= RUN;
                            mult_ctrl <= (op_in == OP_MULT);
`ifdef MULDIV_DIV_EN
                            div_ctrl  <= (op_in == OP_DIV);
`endif
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == cnt_end) begin
                        state     <= CAPTURE;
                        mult_ctrl <= 1'b0;
`ifdef MULDIV_DIV_EN
                        div_ctrl  <= 1'b0;
`endif
                    end
                end
                CAPTURE: begin
`ifdef MULDIV_DIV_EN
                    if (op_q == OP_DIV) begin
                        hi <= div_r;
                        lo <= div_q;
                    end else begin
                        hi <= mult_hi;
                        lo <= mult_lo;
                    end
`else
                    hi <= mult_hi;
                    lo <= mult_lo;
`endif
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural mul/div units.
module tb_muldiv_ctrl;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mult_ctrl;
    logic        div_ctrl;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    int mult_on;
    int div_on;
    int busy_n;
    int done_n;
    int done_at;
    bit ended;

    logic [63:0] mres;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .op_a      (op_a),
        .op_b      (op_b),
        .mult_ctrl (mult_ctrl),
        .div_ctrl  (div_ctrl),
        .mult_hi   (mult_hi),
        .mult_lo   (mult_lo),
        .div_q     (div_q),
        .div_r     (div_r),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Signed multiplier and unsigned divider, cleared while control is low.
    always_ff @(posedge clk) begin
        if (!mult_ctrl)
            mres <= '0;
        else
            mres <= longint'($signed(op_a)) * longint'($signed(op_b));
    end
    assign mult_hi = mres[63:32];
    assign mult_lo = mres[31:0];

    always_ff @(posedge clk) begin
        if (!div_ctrl || op_b == 32'd0) begin
            div_q <= '0;
            div_r <= '0;
        end else begin
            div_q <= op_a / op_b;
            div_r <= op_a % op_b;
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic o, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        mult_on = 0; div_on = 0; busy_n = 0;
        done_n = 0; done_at = -1; ended = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (hold) rs_val = 32'd9;
            else      start  = 1'b0;
            if (mult_ctrl) mult_on++;
            if (div_ctrl)  div_on++;
            if (busy)      busy_n++;
            if (done) begin
                done_n++;
                done_at = j;
            end
            if (!busy) begin
                ended = 1'b1;
                break;
            end
        end
        check("op_timeout", 64'(ended), 64'd1);
    endtask

    task automatic wait_idle();
        ended  = 1'b0;
        done_n = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (done) done_n++;
            if (!busy) begin
                ended = 1'b1;
                break;
            end
        end
        check("idle_timeout", 64'(ended), 64'd1);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b1;
        op     = 1'b0;
        rs_val = 32'h1234;
        rt_val = 32'd5;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err",  64'(err),  64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_opab", {op_a, op_b}, 64'd0);
        check("rst_ctrl", {62'd0, mult_ctrl, div_ctrl}, 64'd0);
        start = 1'b0;
        reset = 1'b0;

        // 7 * -3 = -21
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        check("mul_ctrl_cyc", 64'(mult_on), 64'd34);
        check("mul_div_cyc",  64'(div_on),  64'd0);
        check("mul_busy_cyc", 64'(busy_n),  64'd36);
        check("mul_done_at",  64'(done_at), 64'd35);
        check("mul_done_n",   64'(done_n),  64'd1);
        check("mul_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mul_err",  64'(err), 64'd0);
        check("mul_opb",  64'(op_b), 64'hFFFF_FFFD);

        // 0x66 * 0x2AAAAAAB = 0x11_00000022 presets HI/LO
        run_op(1'b0, 32'h66, 32'h2AAA_AAAB, 1'b0);
        check("pre_hilo", {hi, lo}, 64'h0000_0011_0000_0022);

        run_op(1'b1, 32'd5, 32'd0, 1'b0);
        check("dz_done_at", 64'(done_at), 64'd0);
        check("dz_busy",    64'(busy_n),  64'd1);
        check("dz_div_cyc", 64'(div_on),  64'd0);
        check("dz_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
        repeat (3) @(negedge clk);
        check("dz_err_held", 64'(err), 64'd1);

        run_op(1'b1, 32'd100, 32'd7, 1'b0);
        check("div_err",     64'(err), DIV_EN ? 64'd0 : 64'd1);
        check("div_cyc",     64'(div_on), DIV_EN ? 64'd34 : 64'd0);
        check("div_done_at", 64'(done_at), DIV_EN ? 64'd35 : 64'd0);
        check("div_hilo", {hi, lo},
              DIV_EN ? 64'h0000_0002_0000_000E
                     : 64'h0000_0011_0000_0022);

        run_op(1'b1, 32'd10, 32'd2, 1'b0);
        check("div2_err", 64'(err), DIV_EN ? 64'd0 : 64'd1);
        check("div2_cyc", 64'(div_on), DIV_EN ? 64'd34 : 64'd0);
        check("div2_hilo", {hi, lo},
              DIV_EN ? 64'h0000_0000_0000_0005
                     : 64'h0000_0011_0000_0022);

        // start held high through busy with a new operand
        run_op(1'b0, 32'd7, 32'd5, 1'b1);
        check("hold_opa",    64'(op_a),   64'd7);
        check("hold_done_n", 64'(done_n), 64'd1);
        check("hold_hilo",   {hi, lo},    64'd35);
        check("hold_err",    64'(err),    64'd0);
        @(negedge clk);
        start = 1'b0;
        check("next_busy", 64'(busy), 64'd1);
        check("next_opa",  64'(op_a), 64'd9);
        wait_idle();
        check("next_hilo", {hi, lo}, 64'd45);

        // reset in the middle of a multiply
        @(negedge clk);
        start  = 1'b1;
        op     = 1'b0;
        rs_val = 32'd3;
        rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_hilo", {hi, lo}, 64'd0);
        check("mid_ctrl", 64'(mult_ctrl), 64'd0);
        done_n = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        check("mid_no_done", 64'(done_n), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
